// File: rtl/ship_fire_controller.sv
// ship_fire_controller: fire key to one-hot projectile launch with cooldown and slot reservation
module ship_fire_controller #(
  parameter int NP = 4,
  parameter logic [7:0] FIRE_KEY = 8'h2C,
  parameter int COOLDOWN = 8,
  parameter bit AUTO_FIRE = 1'b0,
  parameter int RES_TIMEOUT = 3
) (
  input  logic frame_clk,
  input  logic Reset,
  input  logic [15:0] keycode,
  input  logic [NP-1:0] ProjBusy,
  output logic [NP-1:0] ProjActvt,
  output logic FireReady,
  output logic [7:0] ShotCount,
  output logic [NP-1:0] SlotsFree
);
  typedef enum logic {IDLE, COOL} state_t;
  state_t state, state_nx;
  logic key_prev, fire_now, trig, any_free, fire;
  logic [7:0] cd, cd_nx;
  logic [NP-1:0] reserved, sel;
  logic [NP-1:0][2:0] age;
  assign fire_now = keycode[7:0] == FIRE_KEY || keycode[15:8] == FIRE_KEY;
  assign trig = AUTO_FIRE ? fire_now : fire_now & ~key_prev;
  assign SlotsFree = ~(ProjBusy | reserved);
  assign any_free = |SlotsFree;
  // two's complement isolates the lowest set bit: the lowest free slot
  assign sel = SlotsFree & -SlotsFree;
  assign FireReady = state == IDLE && any_free;
  assign fire = FireReady && trig;
  always_comb begin
    state_nx = state == IDLE ? (fire ? COOL : IDLE) : (cd == 8'd1 ? IDLE : COOL);
    cd_nx = state == IDLE ? (fire ? 8'(COOLDOWN) : cd) : cd - 8'd1;
  end
  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      cd <= '0;
      key_prev <= 1'b0;
      ProjActvt <= '0;
      ShotCount <= '0;
      reserved <= '0;
      age <= '0;
    end else begin
      state <= state_nx;
      cd <= cd_nx;
      key_prev <= fire_now;
      ProjActvt <= fire ? sel : '0;
      ShotCount <= ShotCount + 8'(fire);
      for (int i = 0; i < NP; i++)
        if (fire && sel[i]) begin
          reserved[i] <= 1'b1;
          age[i] <= 3'd1;
        end else if (reserved[i]) begin
          if (ProjBusy[i] || age[i] == 3'(RES_TIMEOUT)) reserved[i] <= 1'b0;
          else age[i] <= age[i] + 3'd1;
        end
    end
  end
endmodule

// File: tb/tb_ship_fire_controller.sv
// tb_ship_fire_controller: checks a one-shot and an auto-fire instance against a frame-stamped model
module tb_ship_fire_controller;
  localparam int COOLDOWN = 8;
  localparam int RES_TIMEOUT = 3;
  logic frame_clk = 1'b0;
  logic Reset;
  logic [15:0] keycode = '0;
  logic [3:0] busy [2];
  logic [3:0] act [2];
  logic [3:0] free [2];
  logic ready [2];
  logic [7:0] count [2];
  int n_cmp = 0;
  int n_bad = 0;
  int t = 0;
  bit prev [2];
  int next_ok [2];
  int res_end [2][4];
  logic [3:0] pend [2];
  logic [7:0] m_cnt [2];
  logic [3:0] e_free [2];
  logic [3:0] e_act [2];
  logic e_ready [2];
  logic [7:0] e_cnt [2];

  always #5 frame_clk = ~frame_clk;

  ship_fire_controller #(.AUTO_FIRE(1'b0)) dut0 (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode), .ProjBusy(busy[0]),
    .ProjActvt(act[0]), .FireReady(ready[0]), .ShotCount(count[0]), .SlotsFree(free[0]));
  ship_fire_controller #(.AUTO_FIRE(1'b1)) dut1 (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode), .ProjBusy(busy[1]),
    .ProjActvt(act[1]), .FireReady(ready[1]), .ShotCount(count[1]), .SlotsFree(free[1]));

  function automatic bit is_fire(logic [15:0] k);
    return k[7:0] == 8'h2C || k[15:8] == 8'h2C;
  endfunction

  // model: cooldown and reservations are frame stamps, not counters
  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      prev[d] = 1'b0;
      next_ok[d] = t;
      pend[d] = '0;
      m_cnt[d] = '0;
      for (int i = 0; i < 4; i++) res_end[d][i] = 0;
    end
  endtask

  task automatic model_expect();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) e_free[d][i] = !busy[d][i] && t >= res_end[d][i];
      e_ready[d] = (|e_free[d]) && t >= next_ok[d];
      e_act[d] = pend[d];
      e_cnt[d] = m_cnt[d];
    end
  endtask

  task automatic model_step();
    bit fn, trig;
    int s;
    fn = is_fire(keycode);
    for (int d = 0; d < 2; d++) begin
      trig = (d == 1) ? fn : (fn && !prev[d]);
      for (int i = 0; i < 4; i++) if (busy[d][i] && t < res_end[d][i]) res_end[d][i] = t + 1;
      pend[d] = '0;
      if (e_ready[d] && trig) begin
        s = 0;
        while (s < 3 && !e_free[d][s]) s++;
        pend[d][s] = 1'b1;
        m_cnt[d] = m_cnt[d] + 8'd1;
        next_ok[d] = t + 1 + COOLDOWN;
        res_end[d][s] = t + 1 + RES_TIMEOUT;
      end
      prev[d] = fn;
    end
    t++;
  endtask

  task automatic tick(input logic [15:0] k, input logic [3:0] b0, input logic [3:0] b1, input logic r);
    if (Reset) model_step();
    else begin
      t++;
      model_reset();
    end
    @(negedge frame_clk);
    keycode = k;
    busy[0] = b0;
    busy[1] = b1;
    Reset = r;
    #1;
    model_expect();
  endtask

  task automatic test_reset();
    repeat (3) tick(16'h0, 4'h0, 4'h0, 1'b0);
    tick(16'h0, 4'h0, 4'h0, 1'b1);
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (act[d] !== 4'h0 || count[d] !== 8'h00 || ready[d] !== 1'b1 || free[d] !== 4'hF) begin
        n_bad++;
        $display("FAIL reset d%0d act=%h cnt=%0d rdy=%b free=%h want 0/0/1/F", d, act[d], count[d], ready[d], free[d]);
      end
    end
  endtask

  task automatic test_single_shot();
    tick(16'h002C, 4'h0, 4'h0, 1'b1);
    tick(16'h0, 4'h0, 4'h0, 1'b1);
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (act[d] !== 4'b0001 || count[d] !== 8'd1 || ready[d] !== 1'b0) begin
        n_bad++;
        $display("FAIL single_shot d%0d act=%h cnt=%0d rdy=%b want 1/1/0", d, act[d], count[d], ready[d]);
      end
    end
    tick(16'h0, 4'b0001, 4'b0001, 1'b1);
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (act[d] !== 4'h0 || ready[d] !== 1'b0) begin
        n_bad++;
        $display("FAIL pulse_width d%0d act=%h rdy=%b want 0/0", d, act[d], ready[d]);
      end
    end
    for (int k = 3; k <= 9; k++) begin
      tick(16'h0, 4'h0, 4'h0, 1'b1);
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (ready[d] !== (k == 9)) begin
          n_bad++;
          $display("FAIL cooldown d%0d frame N+%0d rdy=%b want %b", d, k, ready[d], k == 9);
        end
        if (k == 3) begin
          n_cmp++;
          if (free[d] !== 4'hF) begin
            n_bad++;
            $display("FAIL busy_clear d%0d free=%h want F", d, free[d]);
          end
        end
      end
    end
  endtask

  task automatic test_hold();
    logic [3:0] b [2];
    int pulses [2];
    for (int d = 0; d < 2; d++) begin
      b[d] = '0;
      pulses[d] = 0;
    end
    for (int f = 0; f < 30; f++) begin
      tick(16'h2C00, b[0], b[1], 1'b1);
      for (int d = 0; d < 2; d++) begin
        if (act[d] != 4'h0) pulses[d]++;
        n_cmp++;
        if (act[d] !== e_act[d] || count[d] !== e_cnt[d]) begin
          n_bad++;
          $display("FAIL hold d%0d f%0d act=%h/%h cnt=%0d/%0d", d, f, act[d], e_act[d], count[d], e_cnt[d]);
        end
        b[d] = b[d] | e_act[d];
      end
    end
    n_cmp++;
    if (pulses[0] != 1 || pulses[1] != 4) begin
      n_bad++;
      $display("FAIL hold_pulses got %0d/%0d want 1/4", pulses[0], pulses[1]);
    end
    repeat (12) tick(16'h0, 4'h0, 4'h0, 1'b1);
  endtask

  task automatic test_no_free();
    tick(16'h002C, 4'hF, 4'hF, 1'b1);
    tick(16'h0, 4'hF, 4'hF, 1'b1);
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (act[d] !== 4'h0 || count[d] !== e_cnt[d] || ready[d] !== 1'b0) begin
        n_bad++;
        $display("FAIL no_free d%0d act=%h cnt=%0d/%0d rdy=%b", d, act[d], count[d], e_cnt[d], ready[d]);
      end
    end
    tick(16'h002C, 4'b1011, 4'b1011, 1'b1);
    tick(16'h0, 4'b1011, 4'b1011, 1'b1);
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (act[d] !== 4'b0100) begin
        n_bad++;
        $display("FAIL slot_select d%0d act=%h want 4", d, act[d]);
      end
    end
    repeat (12) tick(16'h0, 4'h0, 4'h0, 1'b1);
  endtask

  task automatic test_timeout();
    tick(16'h002C, 4'h0, 4'h0, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      tick(16'h0, 4'h0, 4'h0, 1'b1);
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (free[d][0] !== (k == 4)) begin
          n_bad++;
          $display("FAIL res_timeout d%0d frame N+%0d free0=%b want %b", d, k, free[d][0], k == 4);
        end
      end
    end
    repeat (10) tick(16'h0, 4'h0, 4'h0, 1'b1);
  endtask

  task automatic test_reset_mid();
    tick(16'h002C, 4'h0, 4'h0, 1'b1);
    repeat (4) tick(16'h0, 4'h0, 4'h0, 1'b1);
    #2 Reset = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (act[d] !== 4'h0 || count[d] !== 8'h00 || ready[d] !== 1'b1 || free[d] !== 4'hF) begin
        n_bad++;
        $display("FAIL reset_cool d%0d act=%h cnt=%0d rdy=%b free=%h", d, act[d], count[d], ready[d], free[d]);
      end
    end
    tick(16'h0, 4'h0, 4'h0, 1'b0);
    tick(16'h0, 4'h0, 4'h0, 1'b1);
    tick(16'h002C, 4'h0, 4'h0, 1'b1);
    tick(16'h0, 4'h0, 4'h0, 1'b1);
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (act[d] !== 4'b0001 || count[d] !== 8'd1) begin
        n_bad++;
        $display("FAIL fire_after_reset d%0d act=%h cnt=%0d want 1/1", d, act[d], count[d]);
      end
    end
    repeat (9) tick(16'h0, 4'h0, 4'h0, 1'b1);
    tick(16'h002C, 4'h0, 4'h0, 1'b1);
    tick(16'h0, 4'h0, 4'h0, 1'b1);
    #2 Reset = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (act[d] !== 4'h0 || count[d] !== 8'h00) begin
        n_bad++;
        $display("FAIL reset_pulse d%0d act=%h cnt=%0d want 0/0", d, act[d], count[d]);
      end
    end
    tick(16'h0, 4'h0, 4'h0, 1'b0);
    tick(16'h0, 4'h0, 4'h0, 1'b1);
  endtask

  task automatic test_random();
    logic [3:0] b [2];
    logic [15:0] k;
    b[0] = '0;
    b[1] = '0;
    for (int f = 0; f < 1500; f++) begin
      case ($urandom_range(0, 3))
        0: k = 16'h0;
        1: k = 16'h002C;
        2: k = 16'h2C00;
        default: k = 16'($urandom);
      endcase
      for (int d = 0; d < 2; d++) if ($urandom_range(0, 3) == 0) b[d] = 4'($urandom);
      tick(k, b[0], b[1], 1'b1);
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (act[d] !== e_act[d] || free[d] !== e_free[d] || ready[d] !== e_ready[d] || count[d] !== e_cnt[d]) begin
          n_bad++;
          $display("FAIL random d%0d f%0d act=%h/%h free=%h/%h rdy=%b/%b cnt=%0d/%0d", d, f,
                   act[d], e_act[d], free[d], e_free[d], ready[d], e_ready[d], count[d], e_cnt[d]);
        end
      end
    end
  endtask

  task automatic test_wrap();
    tick(16'h0, 4'h0, 4'h0, 1'b0);
    tick(16'h0, 4'h0, 4'h0, 1'b1);
    for (int s = 0; s < 256; s++) begin
      tick(16'h002C, 4'h0, 4'h0, 1'b1);
      repeat (9) tick(16'h0, 4'h0, 4'h0, 1'b1);
      if (s == 254)
        for (int d = 0; d < 2; d++) begin
          n_cmp++;
          if (count[d] !== 8'hFF) begin
            n_bad++;
            $display("FAIL count_255 d%0d cnt=%0d want 255", d, count[d]);
          end
        end
    end
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (count[d] !== 8'h00 || count[d] !== e_cnt[d]) begin
        n_bad++;
        $display("FAIL count_wrap d%0d cnt=%0d want 0", d, count[d]);
      end
    end
  endtask

  initial begin
    Reset = 1'b1;
    busy[0] = '0;
    busy[1] = '0;
    model_reset();
    #2 Reset = 1'b0;
    test_reset();
    test_single_shot();
    test_hold();
    test_no_free();
    test_timeout();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ship_fire_controller.md
Name: ship_fire_controller

Overview:
- Upstream stage of the ship projectile controller. Turns the player's fire key into at most one one-hot activation pulse per shot, aimed at the lowest-index free projectile slot.
- Enforces edge-triggered or auto-repeat firing, a cooldown between shots, and a reservation handshake so that one slot is never issued twice before it reports busy.
- Runs on the frame clock; one cycle is one frame.

Parameters:
- NP, 4, number of projectile slots; must match the projectile array width.
- FIRE_KEY, 8'h2C, HID usage code of the fire key (space).
- COOLDOWN, 8, frames after a shot before another shot is accepted; valid range 1..255.
- AUTO_FIRE, 0, 0 = one shot per press; 1 = repeat while held, paced by COOLDOWN.
- RES_TIMEOUT, 3, frames a reservation waits for busy before being dropped; valid range 1..7.

Ports:
- frame_clk  in  1  frame clock; all state updates on its rising edge.
- Reset  in  1  asynchronous, active-low reset.
- keycode  in  16  two HID key bytes, keycode[7:0] and keycode[15:8].
- ProjBusy  in  NP  per-slot in-flight status from the projectile array.
- ProjActvt  out  NP  one-hot, one-cycle launch pulse to the selected slot.
- FireReady  out  1  high when a fire press this frame would be accepted.
- ShotCount  out  8  total shots issued; wraps 255 -> 0.
- SlotsFree  out  NP  combinational ~(ProjBusy | reserved).

Behaviour:
- Reset asserted (low): ProjActvt=0, ShotCount=0, reserved=0, cooldown counter=0, state=IDLE, key_prev=0. SlotsFree then equals ~ProjBusy.
- fire_now = (keycode[7:0]==FIRE_KEY) | (keycode[15:8]==FIRE_KEY). key_prev is fire_now registered.
- Trigger condition:
  - AUTO_FIRE=0: trig = fire_now & ~key_prev.
  - AUTO_FIRE=1: trig = fire_now.
- Slot select: lowest index i with SlotsFree[i]=1. any_free = |SlotsFree.
- FireReady = (state==IDLE) & any_free.
- State IDLE:
  - If trig & any_free: next cycle ProjActvt = onehot(i) for exactly one cycle, reserved[i] set, ShotCount+1, cooldown loaded with COOLDOWN, go to COOL.
  - If trig with no free slot: shot dropped, stay IDLE, no pulse.
  - AUTO_FIRE=0: a dropped press does not retry while the key is held; a new press is required.
- State COOL: cooldown decrements each frame.
  - When it reaches 0, go to IDLE in the same transition.
  - trig in COOL is ignored (not queued).
  - COOLDOWN=1: one frame in COOL, so shots occur at most every 2 frames.
  - AUTO_FIRE=0 with the key held through COOL: no shot, because there is no new edge.
- Latency: trigger frame N -> ProjActvt high in frame N+1 (registered output).
- Reservation per slot, 3-bit age counter:
  - Cleared when ProjBusy[i]=1 is sampled, or when age reaches RES_TIMEOUT.
  - A reserved slot is not free even if ProjBusy[i]=0.
  - Clear and a new set in the same cycle cannot collide, because a reserved slot is never selected.
- ProjBusy falling (slot freed by collision or leaving the screen) takes effect combinationally in SlotsFree the same cycle.
- Reset asserted mid-cooldown or mid-pulse: everything clears immediately (async). A pulse in progress is truncated.
- ShotCount wraps 8'hFF -> 8'h00 with no flag.
- ProjActvt is never multi-hot and never high on two consecutive cycles.

Test Plan:
- Reset low 3 frames, then high, keycode=0, ProjBusy=0 -> ProjActvt=0, ShotCount=0, FireReady=1, SlotsFree=4'hF.
- keycode=16'h002C for 1 frame at N, ProjBusy=0 -> ProjActvt=4'b0001 at N+1 only; ShotCount=1; FireReady=0 for 8 frames; reserved[0] clears when ProjBusy[0] is driven high at N+2.
- AUTO_FIRE=0, keycode=16'h2C00 held 30 frames -> exactly one pulse. AUTO_FIRE=1, same stimulus -> pulses every 9 frames, cycling slots 0,1,2,3 as each reports busy.
- ProjBusy=4'hF, press -> no pulse, ShotCount unchanged. ProjBusy=4'b1011, press -> ProjActvt=4'b0100.
- Pulse to slot 0, ProjBusy held 0 -> slot 0 stays reserved for 3 frames, then SlotsFree[0]=1 again.
- Reset pulsed low during COOL (counter=5) -> FireReady=1 after release; next press fires at once. 256 shots -> ShotCount=0.
